// File: rtl/disc_pkg.sv
// disc_pkg: shared state encoding and default sizes for the discriminator conditioner
package disc_pkg;
  typedef enum logic [1:0] {IDLE, FIRE, DEAD, WAIT_HIGH} state_t;
  localparam int SYNC_STAGES_D = 2;
  localparam int FILT_LEN_D    = 3;
  localparam int DEAD_W_D      = 8;
  localparam int PILEUP_W      = 16;
endpackage

// File: rtl/disc_chan.sv
// disc_chan: one discriminator channel (sync, glitch filter, hit FSM, dead time, optional pileup count)
// Ports: clk, rst (async, active-high), en, dead_time, disc_in (raw, active-low),
//        disc_out_n (one-cycle active-low hit pulse), busy (FIRE/DEAD/WAIT_HIGH);
//        with DISC_PILEUP_CNT_EN also pileup_clr and pileup_cnt.
module disc_chan import disc_pkg::*; #(
  parameter int SYNC_STAGES = SYNC_STAGES_D,
  parameter int FILT_LEN    = FILT_LEN_D,
  parameter int DEAD_W      = DEAD_W_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DEAD_W-1:0] dead_time,
  input  logic              disc_in,
  output logic              disc_out_n,
  output logic              busy
`ifdef DISC_PILEUP_CNT_EN
  ,
  input  logic                pileup_clr,
  output logic [PILEUP_W-1:0] pileup_cnt
`endif
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic [FILT_LEN-1:0]    r_hist;
  logic                   r_filt;
  state_t                 r_state;
  logic [DEAD_W-1:0]      r_cnt;
  logic                   r_out_n;
  logic                   r_busy;
  logic                   w_sync;
  logic [FILT_LEN-1:0]    w_hist;
  logic                   w_filt;
  logic                   w_settled;
  assign w_sync = r_sync[SYNC_STAGES-1];
  // The filter decision looks at the history including the sample being shifted in,
  // so the filtered level moves on the same edge the last agreeing sample arrives.
  assign w_hist = (r_hist << 1) | FILT_LEN'(w_sync);
  assign w_filt = &w_hist ? 1'b1 : ~|w_hist ? 1'b0 : r_filt;
  // A channel with a high filtered level may rest in IDLE even while disabled.
  assign w_settled = r_filt && (r_state == IDLE || r_state == WAIT_HIGH);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '1;
      r_hist <= '1;
      r_filt <= 1'b1;
    end else begin
      r_sync <= (r_sync << 1) | SYNC_STAGES'(disc_in);
      r_hist <= w_hist;
      r_filt <= w_filt;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_out_n <= 1'b1;
      r_busy  <= 1'b0;
    end else if (!en) begin
      // Parking a low level in WAIT_HIGH keeps re-enable from firing on a stale hit.
      r_out_n <= 1'b1;
      r_state <= w_settled ? IDLE : WAIT_HIGH;
      r_busy  <= !w_settled;
    end else begin
      case (r_state)
        IDLE: if (!r_filt) begin
          r_state <= FIRE;
          r_out_n <= 1'b0;
          r_busy  <= 1'b1;
        end
        FIRE: begin
          r_out_n <= 1'b1;
          r_cnt   <= dead_time;
          r_state <= (dead_time == '0) ? WAIT_HIGH : DEAD;
        end
        DEAD: begin
          r_cnt <= r_cnt - DEAD_W'(1);
          if (r_cnt == DEAD_W'(1)) r_state <= WAIT_HIGH;
        end
        default: if (r_filt) begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end
  assign disc_out_n = r_out_n;
  assign busy       = r_busy;
`ifdef DISC_PILEUP_CNT_EN
  logic [PILEUP_W-1:0] r_pileup;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pileup <= '0;
    else if (pileup_clr) r_pileup <= '0;
    else if (r_state == DEAD && r_filt && !w_filt && r_pileup != '1) r_pileup <= r_pileup + PILEUP_W'(1);
  end
  assign pileup_cnt = r_pileup;
`endif
endmodule

// File: rtl/disc_conditioner.sv
// disc_conditioner: N_CH independent discriminator conditioning channels
// Ports: clk, rst (async, active-high), en, dead_time, disc_in[N_CH] (raw, active-low),
//        disc_out_n[N_CH] (one-cycle active-low hit pulses), busy[N_CH];
//        with DISC_PILEUP_CNT_EN also pileup_clr and pileup_cnt (16 bits per channel, ch i at [16i+15:16i]).
module disc_conditioner import disc_pkg::*; #(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = SYNC_STAGES_D,
  parameter int FILT_LEN    = FILT_LEN_D,
  parameter int DEAD_W      = DEAD_W_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DEAD_W-1:0] dead_time,
  input  logic [N_CH-1:0]   disc_in,
  output logic [N_CH-1:0]   disc_out_n,
  output logic [N_CH-1:0]   busy
`ifdef DISC_PILEUP_CNT_EN
  ,
  input  logic                     pileup_clr,
  output logic [N_CH*PILEUP_W-1:0] pileup_cnt
`endif
);
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    disc_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_LEN   (FILT_LEN),
      .DEAD_W     (DEAD_W)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .dead_time (dead_time),
      .disc_in   (disc_in[i]),
      .disc_out_n(disc_out_n[i]),
      .busy      (busy[i])
`ifdef DISC_PILEUP_CNT_EN
      ,
      .pileup_clr(pileup_clr),
      .pileup_cnt(pileup_cnt[i*PILEUP_W +: PILEUP_W])
`endif
    );
  end
endmodule

// File: tb/tb_disc_conditioner.sv
// tb_disc_conditioner: directed self-checking bench for disc_conditioner
module tb_disc_conditioner;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic [7:0] dead_time = 8'd4;
  logic [3:0] disc_in = 4'hF;
  logic [3:0] disc_out_n;
  logic [3:0] busy;
`ifdef DISC_PILEUP_CNT_EN
  logic        pileup_clr = 1'b0;
  logic [63:0] pileup_cnt;
`endif
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int pulse_cnt[4];
  int last_pulse[4];
  int busy_first[4];
  int busy_last[4];
  always #5 clk = ~clk;
  disc_conditioner dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .dead_time (dead_time),
    .disc_in   (disc_in),
    .disc_out_n(disc_out_n),
    .busy      (busy)
`ifdef DISC_PILEUP_CNT_EN
    ,
    .pileup_clr(pileup_clr),
    .pileup_cnt(pileup_cnt)
`endif
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 4; i++) begin
        if (!disc_out_n[i]) begin
          pulse_cnt[i]++;
          last_pulse[i] = cyc;
        end
        if (busy[i]) begin
          if (busy_first[i] < 0) busy_first[i] = cyc;
          busy_last[i] = cyc;
        end
      end
    end
  endtask
  task automatic clear();
    for (int i = 0; i < 4; i++) begin
      pulse_cnt[i] = 0;
      last_pulse[i] = -1;
      busy_first[i] = -1;
      busy_last[i] = -1;
    end
  endtask
  initial begin
    int t0;
    clear();
    step(2);
    check("rst_out", disc_out_n, 4'hF);
    check("rst_busy", busy, 4'h0);
    rst = 1'b0;
    step(3);
    check("idle_out", disc_out_n, 4'hF);
    // single hit on ch0, dead_time 4
    clear();
    dead_time = 8'd4;
    t0 = cyc + 1;
    disc_in[0] = 1'b0;
    step(10);
    disc_in[0] = 1'b1;
    step(15);
    check("ch0_pulses", pulse_cnt[0], 1);
    check("ch0_latency", last_pulse[0], t0 + 5);
    check("ch0_busy_rise", busy_first[0], t0 + 5);
    check("ch0_busy_fall", busy_last[0], t0 + 14);
    check("ch0_others_quiet", pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3], 0);
    // dead time longer than the input pulse sets busy length
    clear();
    dead_time = 8'd12;
    t0 = cyc + 1;
    disc_in[0] = 1'b0;
    step(10);
    disc_in[0] = 1'b1;
    step(15);
    check("dead12_pulses", pulse_cnt[0], 1);
    check("dead12_busy_fall", busy_last[0], t0 + 18);
    // short glitch on ch1
    clear();
    disc_in[1] = 1'b0;
    step(2);
    disc_in[1] = 1'b1;
    step(12);
    check("glitch_pulses", pulse_cnt[1], 0);
    check("glitch_busy", busy_first[1], -1);
    // second hit inside dead time on ch2
    clear();
    dead_time = 8'd10;
    disc_in[2] = 1'b0;
    step(4);
    disc_in[2] = 1'b1;
    step(3);
    disc_in[2] = 1'b0;
    step(4);
    disc_in[2] = 1'b1;
    step(25);
    check("pileup_pulses", pulse_cnt[2], 1);
`ifdef DISC_PILEUP_CNT_EN
    check("pileup_cnt_ch2", pileup_cnt[47:32], 16'd1);
    check("pileup_cnt_ch0", pileup_cnt[15:0], 16'd0);
    pileup_clr = 1'b1;
    step(1);
    pileup_clr = 1'b0;
    check("pileup_clr", pileup_cnt, 64'd0);
`endif
    // zero dead time, repeated hits on ch3
    clear();
    dead_time = 8'd0;
    for (int k = 0; k < 5; k++) begin
      t0 = cyc + 1;
      disc_in[3] = 1'b0;
      step(4);
      disc_in[3] = 1'b1;
      step(4);
      check($sformatf("rep_latency_%0d", k), last_pulse[3], t0 + 5);
    end
    step(6);
    check("rep_pulses", pulse_cnt[3], 5);
    // simultaneous hits
    clear();
    dead_time = 8'd3;
    disc_in = 4'h0;
    step(6);
    check("simul_out", disc_out_n, 4'h0);
    step(4);
    disc_in = 4'hF;
    step(12);
    for (int i = 0; i < 4; i++) check($sformatf("simul_pulses_%0d", i), pulse_cnt[i], 1);
    // reset during FIRE truncates the pulse
    clear();
    dead_time = 8'd20;
    disc_in[0] = 1'b0;
    step(6);
    check("fire_pre_rst", disc_out_n[0], 1'b0);
    rst = 1'b1;
    #1;
    check("fire_rst_out", disc_out_n, 4'hF);
    check("fire_rst_busy", busy, 4'h0);
    disc_in[0] = 1'b1;
    step(3);
    rst = 1'b0;
    step(10);
    check("fire_rst_pulses", pulse_cnt[0], 1);
    // reset during DEAD
    clear();
    disc_in[0] = 1'b0;
    step(10);
    check("dead_pre_rst_busy", busy[0], 1'b1);
    rst = 1'b1;
    #1;
    check("dead_rst_out", disc_out_n, 4'hF);
    check("dead_rst_busy", busy, 4'h0);
    disc_in[0] = 1'b1;
    step(2);
    rst = 1'b0;
    step(10);
    check("dead_rst_pulses", pulse_cnt[0], 1);
    // enable dropped while ch0 held low
    clear();
    dead_time = 8'd2;
    disc_in[0] = 1'b0;
    step(10);
    en = 1'b0;
    step(3);
    check("en_off_out", disc_out_n, 4'hF);
    check("en_off_busy", busy[0], 1'b1);
    en = 1'b1;
    step(15);
    check("en_held_pulses", pulse_cnt[0], 1);
    disc_in[0] = 1'b1;
    step(8);
    check("en_idle_busy", busy[0], 1'b0);
    en = 1'b0;
    disc_in[0] = 1'b0;
    step(8);
    check("en_off_low_busy", busy[0], 1'b1);
    en = 1'b1;
    step(12);
    check("en_reenable_pulses", pulse_cnt[0], 1);
    disc_in[0] = 1'b1;
    step(8);
    t0 = cyc + 1;
    disc_in[0] = 1'b0;
    step(8);
    check("en_refire_pulses", pulse_cnt[0], 2);
    check("en_refire_latency", last_pulse[0], t0 + 5);
    disc_in = 4'hF;
    step(8);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/disc_conditioner.md
Name: disc_conditioner

Overview:
- Front-end conditioner for N_CH raw, asynchronous, active-low discriminator inputs.
- Per channel: synchronises, glitch-filters, detects the falling edge, and emits exactly one active-low single-cycle pulse per accepted hit.
- Applies a programmable dead time after each hit.
- Output bus drives the per-channel discriminator inputs of the downstream disc counter directly. Idle level high; a low cycle means "count one".

Parameters:
- N_CH, 4, number of discriminator channels.
- SYNC_STAGES, 2, synchroniser flops per channel (min 2).
- FILT_LEN, 3, consecutive agreeing synced samples needed to change the filtered level (min 1).
- DEAD_W, 8, width of the dead-time count.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- en  in  1  conditioner enable.
- dead_time  in  DEAD_W  dead time in clk cycles; sampled per channel at each FIRE.
- disc_in  in  N_CH  raw discriminator inputs, active-low, asynchronous to clk.
- disc_out_n  out  N_CH  conditioned hit pulses, active-low, one cycle, registered.
- busy  out  N_CH  channel is in FIRE, DEAD or WAIT_HIGH.

Behaviour:
- Interface (already decided): one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - Synchroniser flops and filter history set to all 1.
  - Filtered level = 1.
  - FSM = IDLE.
  - disc_out_n = all 1; busy = 0.
- Filter:
  - Shift register of the last FILT_LEN synced samples.
  - Filtered level becomes 0 when all bits are 0 and 1 when all bits are 1; otherwise it holds.
- Per-channel FSM, registered:
  - IDLE: when en=1 and the filtered level is 0, go to FIRE.
  - FIRE: disc_out_n[i]=0 for exactly this one cycle. Latch dead_time into the channel's down-counter. Next state is DEAD, or WAIT_HIGH if dead_time=0.
  - DEAD: decrement each cycle. When the counter reaches 1, go to WAIT_HIGH. Total DEAD duration = dead_time cycles.
  - WAIT_HIGH: stay until the filtered level is 1, then go to IDLE.
- Latency: disc_out_n[i] goes low exactly SYNC_STAGES+FILT_LEN+1 clk edges after the edge that first samples disc_in[i] low (defaults: 6 edges).
- Boundary conditions:
  - Input held low indefinitely: one pulse only, then the channel stays in WAIT_HIGH.
  - Low glitch shorter than FILT_LEN synced cycles: no pulse.
  - en=0: disc_out_n forced to all 1. Every channel not already in IDLE goes to WAIT_HIGH. A channel in IDLE with the filtered level at 0 also goes to WAIT_HIGH, so re-enabling never fires on a level that was already low.
  - Channels are fully independent. Simultaneous hits on several channels produce simultaneous pulses; arbitration is downstream's job.
  - rst mid-DEAD or mid-FIRE: immediate return to the reset state; an in-flight pulse is truncated.
  - dead_time changes mid-DEAD have no effect until the next FIRE.

Optional Feature:
- Macro: DISC_PILEUP_CNT_EN.
- With the macro defined:
  - Adds input pileup_clr (1 bit) and output pileup_cnt (N_CH*16 bits, channel i at bits [16i+15:16i]).
  - A filtered 1->0 transition while the channel is in DEAD increments that channel's 16-bit counter.
  - The counter saturates at 0xFFFF.
  - pileup_clr=1 synchronously zeroes all counters and takes priority over an increment in the same cycle.
  - rst zeroes all counters.
- Without the macro: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package disc_pkg:
  - state enum {IDLE, FIRE, DEAD, WAIT_HIGH}.
  - Default constants SYNC_STAGES_D=2, FILT_LEN_D=3, DEAD_W_D=8, PILEUP_W=16.
- Sub-module disc_chan: one channel, covering the synchroniser, filter, FSM, dead counter and optional pileup counter.
- Top level: generate loop over N_CH plus output packing.

Test Plan:
- Reset, then disc_in[0] low for 10 cycles with dead_time=4 -> disc_out_n[0] low for exactly one cycle, 6 edges after the first sampled low. busy[0] high from FIRE until the filtered level returns high.
- Low glitch of 2 cycles on disc_in[1] -> no pulse on disc_out_n[1]; busy[1] stays 0.
- dead_time=10; two 4-cycle-low pulses on ch2 separated by 3 cycles high -> one output pulse only. With DISC_PILEUP_CNT_EN, pileup_cnt[ch2]=1. Then pileup_clr=1 -> 0.
- dead_time=0; ch3 pulses low 4 cycles / high 4 cycles, repeated 5 times -> 5 output pulses, each 6 edges after its input fall.
- All four channels fall on the same edge -> all four disc_out_n bits low in the same cycle.
- rst asserted mid-DEAD, and en dropped with ch0 held low, then en restored -> outputs all 1 immediately on rst. No pulse after re-enable until ch0 goes high and then low again.
